aes_encipher_core_param: RTL and testbench
==========================================

Name: aes_encipher_core_param

Overview:
Parametrised AES encipher datapath and controller; successor to the fixed AES-256 encipher round block. It supports run-time key length (128/192/256) and a configurable S-box interface width, so area can be traded against latency. It adds abort, a done pulse and a reserved-mode error flag. It sits between the key-expansion memory, which supplies the round key indexed by round, and a shared external S-box array.

Parameters:
SBOX_WORDS, 4, number of 32-bit words substituted per cycle; legal values are 1, 2 and 4; any other value is an elaboration error.

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  reset, synchronous, active-low
next  in  1  start request; sampled only in IDLE
keylen  in  2  00=AES-128, 01=AES-192, 10=AES-256, 11=reserved; sampled with next
abort  in  1  synchronous cancel of the operation in progress
round  out  4  current round index, used to address the round-key memory
round_key  in  128  round key for `round`; combinational, valid in the same cycle
sboxw  out  32*SBOX_WORDS  state words sent to the S-boxes
new_sboxw  in  32*SBOX_WORDS  substituted words, combinational return
block  in  128  plaintext; sampled in INIT
new_block  out  128  state register; holds the ciphertext when ready=1 after done
ready  out  1  core idle and able to accept next
done  out  1  single-cycle pulse when the ciphertext is valid
error  out  1  single-cycle pulse on a start attempted with reserved keylen

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=IDLE, round=0, word_ctr=0.
  - state register = 0, so new_block=0 and sboxw=0.
  - ready=1, done=0, error=0.
- Derived constants:
  - W = 4/SBOX_WORDS cycles per round.
  - Nr = 10/12/14 for keylen 00/01/10; latched at start into nr_reg.
  - keylen changes after start are ignored.
- Word ordering: word 0 = bits 127:96. Group g covers words g*SBOX_WORDS .. g*SBOX_WORDS+SBOX_WORDS-1. The lowest-numbered word of a group sits in the MSBs of sboxw.
- FSM states: IDLE, INIT, ROUND.
- IDLE:
  - next=1, abort=0, keylen!=11: round<=0, ready<=0, go to INIT.
  - next=1, keylen=11: error<=1 for one cycle; stay in IDLE; ready stays 1.
- INIT (one cycle, round=0): state<=block^round_key, round<=1, word_ctr<=0, go to ROUND.
- ROUND:
  - sboxw = group word_ctr of the state register.
  - For a non-last group: new_sboxw is stored in the sub buffer at the group's positions; word_ctr++.
  - On the last group (word_ctr=W-1): the full substituted state is formed from the sub buffer plus the current new_sboxw.
    - round<Nr: state <= MixColumns(ShiftRows(sub)) ^ round_key.
    - round=Nr: state <= ShiftRows(sub) ^ round_key (no MixColumns).
    - Then word_ctr<=0 and round++.
  - After the final round: round stays at Nr, ready<=1, done<=1 for one cycle, go to IDLE.
- GF arithmetic: xtime(b) = {b[6:0],0} ^ (0x1b & {8{b[7]}}). MixColumns uses the standard 2-3-1-1 circulant matrix on each column.
- Latency: next sampled at edge E0 → ready=1 and done=1 after edge E(1+Nr*W).
  - SBOX_WORDS=4: AES-128/192/256 take 11/13/15 cycles.
- new_block stays stable in IDLE until the INIT update of the next operation.
- Boundary conditions:
  - next while busy: ignored.
  - abort in INIT/ROUND: next edge goes to IDLE, state register cleared to 0, round=0, word_ctr=0, ready=1, done stays 0.
  - abort in IDLE: no effect.
  - abort and next together in IDLE: abort wins, no start.
  - abort in the same cycle as the final round update: abort wins, no done.
  - reset_n=0 mid-operation: full reset values at the next edge; no done.
  - Back-to-back operation: next may be asserted in the cycle where ready is first 1. That is the same cycle as done=1.
- round never exceeds 14. The unused S-box lanes beyond the active group do not exist; sboxw is exactly one group wide.

Test Plan:
- FIPS-197 C.3, SBOX_WORDS=4, keylen=10, key 00..1f, block 00112233445566778899aabbccddeeff → new_block=8ea2b7ca516745bfeafc49904b496089, done exactly 15 cycles after next.
- FIPS-197 C.1/C.2 vectors with keylen 00/01, SBOX_WORDS=1 and 2.
  - Expected ciphertexts: 69c4e0d86a7b0430d8cdb78070b4c55a and dda97ca4864cdfe06eaf70a0ec0d7191.
  - Expected latency: 41/21 cycles for AES-128 and 49/25 cycles for AES-192.
- keylen=11 with next → error pulses once, ready stays 1, round=0, new_block unchanged, done never asserts.
- abort asserted at round 5 (AES-256) → next cycle ready=1, new_block=0, round=0, no done. A following next with the C.3 vector gives the correct ciphertext.
- next pulsed again mid-operation, plus keylen toggled mid-run → ignored; result and latency match the first request. Back-to-back start in the done cycle completes correctly.
- reset_n low for one cycle at round 7 → ready=1, done=0, new_block=0, sboxw=0 after the edge. A subsequent run completes correctly.

Source files
------------

// File: rtl/aes_encipher_core_param.sv
// ============================================================================
// aes_encipher_core_param
// ----------------------------------------------------------------------------
// AES encipher datapath and controller with a run-time key length
// (AES-128/192/256) and a configurable S-box interface width.
//
// Each round substitutes the 128-bit state through an external S-box array.
// SBOX_WORDS 32-bit words are substituted per cycle, so one round takes
// W = 4/SBOX_WORDS cycles. The round key comes from an external key-expansion
// memory addressed by o_round and is used combinationally in the same cycle.
//
// Parameters
//   SBOX_WORDS   32-bit words substituted per cycle: 1, 2 or 4
//
// Ports
//   i_clk        system clock, rising edge
//   i_reset_n    synchronous active-low reset
//   i_next       start request, sampled only while idle
//   i_keylen     00=AES-128, 01=AES-192, 10=AES-256, 11=reserved
//   i_abort      synchronous cancel of the operation in progress
//   o_round      current round index, addresses the round-key memory
//   i_round_key  round key for o_round (combinational, same cycle)
//   o_sboxw      state word group sent to the S-boxes
//   i_new_sboxw  substituted words returned by the S-boxes
//   i_block      plaintext, sampled in the INIT cycle
//   o_new_block  state register; ciphertext once done has pulsed
//   o_ready      core idle and able to accept i_next
//   o_done       one-cycle pulse when the ciphertext is valid
//   o_error      one-cycle pulse on a start with reserved key length
// ============================================================================
module aes_encipher_core_param #(
  parameter int SBOX_WORDS = 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_next,
  input  logic [1:0]                i_keylen,
  input  logic                      i_abort,
  output logic [3:0]                o_round,
  input  logic [127:0]              i_round_key,
  output logic [32*SBOX_WORDS-1:0]  o_sboxw,
  input  logic [32*SBOX_WORDS-1:0]  i_new_sboxw,
  input  logic [127:0]              i_block,
  output logic [127:0]              o_new_block,
  output logic                      o_ready,
  output logic                      o_done,
  output logic                      o_error
);

  localparam int GW    = 32 * SBOX_WORDS;           // group width in bits
  localparam int W     = 4 / SBOX_WORDS;            // cycles per round
  localparam int CTR_W = (W > 1) ? $clog2(W) : 1;   // word_ctr width
  localparam logic [CTR_W-1:0] LAST_GRP = CTR_W'(W - 1);

  genvar gi;

  generate
    if ((SBOX_WORDS != 1) && (SBOX_WORDS != 2) && (SBOX_WORDS != 4)) begin : g_bad_param
      $error("aes_encipher_core_param: SBOX_WORDS must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INIT  = 2'd1,
    ST_ROUND = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Registers and their next values
  // --------------------------------------------------------------------------
  state_t             r_fsm;
  logic [127:0]       r_state;
  logic [127:0]       r_sub;       // substituted groups collected so far
  logic [3:0]         r_round;
  logic [3:0]         r_nr;        // number of rounds latched at start
  logic [CTR_W-1:0]   r_word_ctr;
  logic               r_ready;
  logic               r_done;
  logic               r_error;

  state_t             w_fsm_next;
  logic [127:0]       w_state_next;
  logic [127:0]       w_sub_next;
  logic [3:0]         w_round_next;
  logic [3:0]         w_nr_next;
  logic [CTR_W-1:0]   w_word_ctr_next;
  logic               w_ready_next;
  logic               w_done_next;
  logic               w_error_next;

  // --------------------------------------------------------------------------
  // GF(2^8) helpers
  // --------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  // 2-3-1-1 circulant on one column; a0 is the top byte (row 0).
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [3:0] rounds_for(input logic [1:0] kl);
    logic [3:0] nr;
    case (kl)
      2'b00:   nr = 4'd10;
      2'b01:   nr = 4'd12;
      default: nr = 4'd14;
    endcase
    return nr;
  endfunction

  // --------------------------------------------------------------------------
  // S-box interface: one group of the state register goes out per cycle.
  // The full substituted state merges the buffered groups with the group
  // that is coming back this cycle, so the last group never needs a buffer.
  // --------------------------------------------------------------------------
  logic [GW-1:0] w_grp [W];
  logic [127:0]  w_sub_full;

  generate
    for (gi = 0; gi < W; gi++) begin : g_group
      assign w_grp[gi] = r_state[127 - gi*GW -: GW];
      assign w_sub_full[127 - gi*GW -: GW] =
        (r_word_ctr == CTR_W'(gi)) ? i_new_sboxw : r_sub[127 - gi*GW -: GW];
    end
  endgenerate

  assign o_sboxw = w_grp[r_word_ctr];

  // --------------------------------------------------------------------------
  // ShiftRows: byte b sits at column b/4, row b%4; row r rotates left by r.
  // --------------------------------------------------------------------------
  logic [127:0] w_sr;
  logic [127:0] w_mc;
  logic [127:0] w_round_out;
  logic         w_last_round;

  generate
    for (gi = 0; gi < 16; gi++) begin : g_shift
      localparam int COL = gi / 4;
      localparam int ROW = gi % 4;
      localparam int SRC = 4 * ((COL + ROW) % 4) + ROW;
      assign w_sr[127 - 8*gi -: 8] = w_sub_full[127 - 8*SRC -: 8];
    end

    for (gi = 0; gi < 4; gi++) begin : g_mix
      assign w_mc[127 - 32*gi -: 32] = mix_column(w_sr[127 - 32*gi -: 32]);
    end
  endgenerate

  // The final round skips MixColumns.
  assign w_last_round = (r_round == r_nr);
  assign w_round_out  = (w_last_round ? w_sr : w_mc) ^ i_round_key;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_fsm_next      = r_fsm;
    w_state_next    = r_state;
    w_sub_next      = r_sub;
    w_round_next    = r_round;
    w_nr_next       = r_nr;
    w_word_ctr_next = r_word_ctr;
    w_ready_next    = r_ready;
    w_done_next     = 1'b0;
    w_error_next    = 1'b0;

    unique case (r_fsm)
      ST_IDLE: begin
        if (i_next) begin
          if (i_keylen == 2'b11) begin
            w_error_next = 1'b1;
          end else if (!i_abort) begin
            w_round_next = 4'd0;
            w_ready_next = 1'b0;
            w_nr_next    = rounds_for(i_keylen);
            w_fsm_next   = ST_INIT;
          end
        end
      end

      ST_INIT: begin
        // Initial AddRoundKey with round key 0.
        w_state_next    = i_block ^ i_round_key;
        w_round_next    = 4'd1;
        w_word_ctr_next = '0;
        w_fsm_next      = ST_ROUND;
      end

      ST_ROUND: begin
        if (r_word_ctr != LAST_GRP) begin
          w_sub_next      = w_sub_full;
          w_word_ctr_next = r_word_ctr + CTR_W'(1);
        end else begin
          w_state_next    = w_round_out;
          w_word_ctr_next = '0;
          if (w_last_round) begin
            // round stays at Nr so the key memory address is stable in idle.
            w_ready_next = 1'b1;
            w_done_next  = 1'b1;
            w_fsm_next   = ST_IDLE;
          end else begin
            w_round_next = r_round + 4'd1;
          end
        end
      end

      default: begin
        w_fsm_next = ST_IDLE;
      end
    endcase

    // Abort overrides everything in a busy state, including the final update.
    if (i_abort && (r_fsm != ST_IDLE)) begin
      w_fsm_next      = ST_IDLE;
      w_state_next    = '0;
      w_round_next    = 4'd0;
      w_word_ctr_next = '0;
      w_ready_next    = 1'b1;
      w_done_next     = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_fsm      <= ST_IDLE;
      r_state    <= '0;
      r_sub      <= '0;
      r_round    <= 4'd0;
      r_nr       <= 4'd10;
      r_word_ctr <= '0;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_fsm      <= w_fsm_next;
      r_state    <= w_state_next;
      r_sub      <= w_sub_next;
      r_round    <= w_round_next;
      r_nr       <= w_nr_next;
      r_word_ctr <= w_word_ctr_next;
      r_ready    <= w_ready_next;
      r_done     <= w_done_next;
      r_error    <= w_error_next;
    end
  end

  assign o_round     = r_round;
  assign o_new_block = r_state;
  assign o_ready     = r_ready;
  assign o_done      = r_done;
  assign o_error     = r_error;

endmodule

// File: tb/tb_aes_encipher_core_param.sv
// ============================================================================
// tb_aes_encipher_core_param
// ----------------------------------------------------------------------------
// Three instances (SBOX_WORDS = 4, 2, 1) share clock, reset, keylen, abort
// and block; each has its own start line. The bench supplies the S-box and
// a key-schedule memory for the FIPS-197 appendix C keys. Expected results
// are pushed to a scoreboard queue at start and popped when done pulses.
// ============================================================================
module tb_aes_encipher_core_param;

  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY   =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  typedef struct {
    int           dut;
    logic [127:0] ct;
    int           lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n, abort;
  logic [1:0]   keylen;
  logic [127:0] block;
  logic         next4, next2, next1;
  logic [3:0]   round4, round2, round1;
  logic [127:0] rk4, rk2, rk1;
  logic [127:0] sb4, nsb4;
  logic [63:0]  sb2, nsb2;
  logic [31:0]  sb1, nsb1;
  logic [127:0] nb4, nb2, nb1;
  logic         ready4, ready2, ready1;
  logic         done4, done2, done1;
  logic         error4, error2, error1;

  logic [127:0] rk_mem [0:3][0:15];
  logic [1:0]   cur_kl [0:2];

  // ---------------------------------------------------------------- models
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Inverse as x^254 (product of x^2..x^128), then the affine map.
  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq = x; inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox_f(w[31:24]), sbox_f(w[23:16]), sbox_f(w[15:8]), sbox_f(w[7:0])};
  endfunction

  task automatic expand_key(input int kl);
    logic [31:0]  w [0:59];
    logic [31:0]  t;
    logic [7:0]   rcon;
    logic [255:0] key;
    int nk, nr;
    key  = KEY;
    nk   = (kl == 0) ? 4 : (kl == 1) ? 6 : 8;
    nr   = nk + 6;
    rcon = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t    = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      if (r <= nr) rk_mem[kl][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else         rk_mem[kl][r] = '0;
    end
  endtask

  genvar gi;
  for (gi = 0; gi < 16; gi++) begin : g_sb4
    assign nsb4[127 - 8*gi -: 8] = sbox_f(sb4[127 - 8*gi -: 8]);
  end
  for (gi = 0; gi < 8; gi++) begin : g_sb2
    assign nsb2[63 - 8*gi -: 8] = sbox_f(sb2[63 - 8*gi -: 8]);
  end
  for (gi = 0; gi < 4; gi++) begin : g_sb1
    assign nsb1[31 - 8*gi -: 8] = sbox_f(sb1[31 - 8*gi -: 8]);
  end

  assign rk4 = rk_mem[cur_kl[0]][round4];
  assign rk2 = rk_mem[cur_kl[1]][round2];
  assign rk1 = rk_mem[cur_kl[2]][round1];

  // ---------------------------------------------------------------- DUTs
  aes_encipher_core_param #(.SBOX_WORDS(4)) u_dut4 (
    .i_clk(clk), .i_reset_n(reset_n), .i_next(next4), .i_keylen(keylen),
    .i_abort(abort), .o_round(round4), .i_round_key(rk4), .o_sboxw(sb4),
    .i_new_sboxw(nsb4), .i_block(block), .o_new_block(nb4),
    .o_ready(ready4), .o_done(done4), .o_error(error4)
  );

  aes_encipher_core_param #(.SBOX_WORDS(2)) u_dut2 (
    .i_clk(clk), .i_reset_n(reset_n), .i_next(next2), .i_keylen(keylen),
    .i_abort(abort), .o_round(round2), .i_round_key(rk2), .o_sboxw(sb2),
    .i_new_sboxw(nsb2), .i_block(block), .o_new_block(nb2),
    .o_ready(ready2), .o_done(done2), .o_error(error2)
  );

  aes_encipher_core_param #(.SBOX_WORDS(1)) u_dut1 (
    .i_clk(clk), .i_reset_n(reset_n), .i_next(next1), .i_keylen(keylen),
    .i_abort(abort), .o_round(round1), .i_round_key(rk1), .o_sboxw(sb1),
    .i_new_sboxw(nsb1), .i_block(block), .o_new_block(nb1),
    .o_ready(ready1), .o_done(done1), .o_error(error1)
  );

  // ---------------------------------------------------------------- helpers
  function automatic logic dut_done(input int d);
    case (d)
      0:       return done4;
      1:       return done2;
      default: return done1;
    endcase
  endfunction

  function automatic logic [127:0] dut_nb(input int d);
    case (d)
      0:       return nb4;
      1:       return nb2;
      default: return nb1;
    endcase
  endfunction

  task automatic set_next(input int d, input logic v);
    case (d)
      0:       next4 = v;
      1:       next2 = v;
      default: next1 = v;
    endcase
  endtask

  // Drives a start request through edge E0; returns #1 after E0.
  task automatic start_op(input int d, input logic [1:0] kl, input logic [127:0] pt,
                          input logic [127:0] ct, input int lat, input bit push);
    exp_t e;
    if (push) begin
      e.dut = d; e.ct = ct; e.lat = lat;
      sb_q.push_back(e);
    end
    cur_kl[d] = kl;
    keylen    = kl;
    block     = pt;
    set_next(d, 1'b1);
    @(posedge clk); #1;
    set_next(d, 1'b0);
  endtask

  // Counts edges after E0 until done is seen or the budget runs out.
  task automatic wait_done(input int d, input int budget, output int cycles,
                           output logic [127:0] ct, output bit seen);
    cycles = 0; seen = 1'b0; ct = '0;
    while (!seen && cycles < budget) begin
      @(posedge clk); #1;
      cycles++;
      if (dut_done(d) === 1'b1) begin
        seen = 1'b1;
        ct   = dut_nb(d);
      end
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    reset_n = 1'b0; abort = 1'b0; keylen = 2'b00; block = PT;
    next4 = 1'b0; next2 = 1'b0; next1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    n_tests++; if (ready4 !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready4); end
    n_tests++; if (done4 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done4); end
    n_tests++; if (error4 !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", error4); end
    n_tests++; if (round4 !== 4'd0) begin n_fail++; $display("FAIL reset_round: got %0d expected 0", round4); end
    n_tests++; if (nb4 !== 128'h0) begin n_fail++; $display("FAIL reset_new_block: got %h expected 0", nb4); end
    n_tests++; if (sb4 !== 128'h0) begin n_fail++; $display("FAIL reset_sboxw: got %h expected 0", sb4); end
    n_tests++; if ({ready2, ready1, error2, error1} !== 4'b1100) begin
      n_fail++; $display("FAIL reset_narrow: got %b expected 1100", {ready2, ready1, error2, error1});
    end
    $display("[TB] reset applied");
  endtask

  task automatic test_reserved();
    bit seen;
    keylen = 2'b11; next4 = 1'b1;
    @(posedge clk); #1;
    next4 = 1'b0; keylen = 2'b10;
    n_tests++; if (error4 !== 1'b1) begin n_fail++; $display("FAIL reserved_error: got %b expected 1", error4); end
    n_tests++; if (ready4 !== 1'b1) begin n_fail++; $display("FAIL reserved_ready: got %b expected 1", ready4); end
    n_tests++; if (round4 !== 4'd0) begin n_fail++; $display("FAIL reserved_round: got %0d expected 0", round4); end
    n_tests++; if (nb4 !== 128'h0) begin n_fail++; $display("FAIL reserved_new_block: got %h expected 0", nb4); end
    @(posedge clk); #1;
    n_tests++; if (error4 !== 1'b0) begin n_fail++; $display("FAIL reserved_pulse: got %b expected 0", error4); end
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done4 !== 1'b0) seen = 1'b1;
    end
    n_tests++; if (seen) begin n_fail++; $display("FAIL reserved_no_done: got 1 expected 0"); end
    $display("[TB] reserved keylen start rejected");
  endtask

  task automatic test_aes256();
    int cyc; logic [127:0] ct; bit seen; exp_t e;
    start_op(0, 2'b10, PT, CT256, 15, 1'b1);
    n_tests++; if (ready4 !== 1'b0) begin n_fail++; $display("FAIL start_busy: got %b expected 0", ready4); end
    wait_done(0, 40, cyc, ct, seen);
    e = sb_q.pop_front();
    n_tests++; if (!seen) begin n_fail++; $display("FAIL aes256_timeout: got no done expected done"); end
    n_tests++; if (ct !== e.ct) begin n_fail++; $display("FAIL aes256_ct: got %h expected %h", ct, e.ct); end
    n_tests++; if (cyc !== e.lat) begin n_fail++; $display("FAIL aes256_latency: got %0d expected %0d", cyc, e.lat); end
    n_tests++; if ({ready4, round4} !== {1'b1, 4'd14}) begin
      n_fail++; $display("FAIL aes256_end_state: got ready=%b round=%0d expected ready=1 round=14", ready4, round4);
    end
    @(posedge clk); #1;
    n_tests++; if (done4 !== 1'b0) begin n_fail++; $display("FAIL done_pulse: got %b expected 0", done4); end
    n_tests++; if (nb4 !== CT256) begin n_fail++; $display("FAIL idle_hold: got %h expected %h", nb4, CT256); end
    $display("[TB] op dut=4 keylen=10 ct=%h latency=%0d", ct, cyc);
  endtask

  task automatic test_widths();
    int           td [6] = '{0, 0, 1, 1, 2, 2};
    logic [1:0]   tk [6] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
    logic [127:0] tc [6] = '{CT128, CT192, CT128, CT192, CT128, CT192};
    int           tl [6] = '{11, 13, 21, 25, 41, 49};
    int cyc; logic [127:0] ct; bit seen; exp_t e;
    for (int i = 0; i < 6; i++) begin
      start_op(td[i], tk[i], PT, tc[i], tl[i], 1'b1);
      wait_done(td[i], tl[i] + 10, cyc, ct, seen);
      e = sb_q.pop_front();
      n_tests++; if (!seen || ct !== e.ct) begin
        n_fail++; $display("FAIL width_ct[%0d]: got %h expected %h", i, ct, e.ct);
      end
      n_tests++; if (cyc !== e.lat) begin
        n_fail++; $display("FAIL width_latency[%0d]: got %0d expected %0d", i, cyc, e.lat);
      end
      $display("[TB] op dut=%0d keylen=%b ct=%h latency=%0d", 4 >> td[i], tk[i], ct, cyc);
    end
  endtask

  task automatic test_abort();
    int cyc; logic [127:0] ct; bit seen; exp_t e;
    // Abort in the middle of an AES-256 run.
    start_op(0, 2'b10, PT, CT256, 15, 1'b0);
    cyc = 0;
    while (round4 !== 4'd5 && cyc < 30) begin @(posedge clk); #1; cyc++; end
    n_tests++; if (round4 !== 4'd5) begin n_fail++; $display("FAIL abort_reach_round5: got %0d expected 5", round4); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_tests++; if ({ready4, done4, round4} !== {1'b1, 1'b0, 4'd0}) begin
      n_fail++; $display("FAIL abort_ctrl: got ready=%b done=%b round=%0d expected 1 0 0", ready4, done4, round4);
    end
    n_tests++; if (nb4 !== 128'h0) begin n_fail++; $display("FAIL abort_clear: got %h expected 0", nb4); end
    seen = 1'b0;
    repeat (20) begin @(posedge clk); #1; if (done4 !== 1'b0) seen = 1'b1; end
    n_tests++; if (seen) begin n_fail++; $display("FAIL abort_no_done: got 1 expected 0"); end

    // Abort together with next while idle: no start.
    abort = 1'b1; keylen = 2'b10; next4 = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; next4 = 1'b0;
    n_tests++; if (ready4 !== 1'b1) begin n_fail++; $display("FAIL abort_next_idle: got ready=%b expected 1", ready4); end

    // Abort in the cycle of the final round update.
    start_op(0, 2'b10, PT, CT256, 15, 1'b0);
    cyc = 0;
    while (round4 !== 4'd14 && cyc < 30) begin @(posedge clk); #1; cyc++; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_tests++; if ({done4, ready4, nb4} !== {1'b0, 1'b1, 128'h0}) begin
      n_fail++; $display("FAIL abort_final: got done=%b ready=%b nb=%h expected 0 1 0", done4, ready4, nb4);
    end

    // A clean run afterwards.
    start_op(0, 2'b10, PT, CT256, 15, 1'b1);
    wait_done(0, 40, cyc, ct, seen);
    e = sb_q.pop_front();
    n_tests++; if (!seen || ct !== e.ct) begin n_fail++; $display("FAIL abort_rerun_ct: got %h expected %h", ct, e.ct); end
    n_tests++; if (cyc !== e.lat) begin n_fail++; $display("FAIL abort_rerun_latency: got %0d expected %0d", cyc, e.lat); end
    $display("[TB] op after abort ct=%h latency=%0d", ct, cyc);
  endtask

  task automatic test_ignore_next();
    int cyc; logic [127:0] ct; bit seen; exp_t e;
    start_op(0, 2'b10, PT, CT256, 15, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    next4 = 1'b1; keylen = 2'b00; block = ~PT;
    @(posedge clk); #1;
    next4 = 1'b0; keylen = 2'b01;
    n_tests++; if ({ready4, round4} !== {1'b0, 4'd4}) begin
      n_fail++; $display("FAIL busy_next: got ready=%b round=%0d expected 0 4", ready4, round4);
    end
    wait_done(0, 40, cyc, ct, seen);
    cyc += 4;
    e = sb_q.pop_front();
    n_tests++; if (!seen || ct !== e.ct) begin n_fail++; $display("FAIL ignore_ct: got %h expected %h", ct, e.ct); end
    n_tests++; if (cyc !== e.lat) begin n_fail++; $display("FAIL ignore_latency: got %0d expected %0d", cyc, e.lat); end
    block = PT;
    $display("[TB] op with busy next ct=%h latency=%0d", ct, cyc);
  endtask

  task automatic test_back_to_back();
    int cyc; logic [127:0] ct; bit seen; exp_t e;
    start_op(0, 2'b00, PT, CT128, 11, 1'b1);
    wait_done(0, 30, cyc, ct, seen);
    e = sb_q.pop_front();
    n_tests++; if (!seen || ct !== e.ct || cyc !== e.lat) begin
      n_fail++; $display("FAIL b2b_first: got %h/%0d expected %h/%0d", ct, cyc, e.ct, e.lat);
    end
    $display("[TB] op b2b first ct=%h latency=%0d", ct, cyc);
    n_tests++; if (ready4 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_in_done: got %b expected 1", ready4); end
    start_op(0, 2'b10, PT, CT256, 15, 1'b1);
    n_tests++; if (ready4 !== 1'b0) begin n_fail++; $display("FAIL b2b_accept: got ready=%b expected 0", ready4); end
    wait_done(0, 30, cyc, ct, seen);
    e = sb_q.pop_front();
    n_tests++; if (!seen || ct !== e.ct) begin n_fail++; $display("FAIL b2b_ct: got %h expected %h", ct, e.ct); end
    n_tests++; if (cyc !== e.lat) begin n_fail++; $display("FAIL b2b_latency: got %0d expected %0d", cyc, e.lat); end
    $display("[TB] op b2b second ct=%h latency=%0d", ct, cyc);
  endtask

  task automatic test_reset_mid();
    int cyc; logic [127:0] ct; bit seen; exp_t e;
    start_op(0, 2'b10, PT, CT256, 15, 1'b0);
    cyc = 0;
    while (round4 !== 4'd7 && cyc < 30) begin @(posedge clk); #1; cyc++; end
    n_tests++; if (round4 !== 4'd7) begin n_fail++; $display("FAIL rst_reach_round7: got %0d expected 7", round4); end
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    n_tests++; if ({ready4, done4, round4} !== {1'b1, 1'b0, 4'd0}) begin
      n_fail++; $display("FAIL rst_mid_ctrl: got ready=%b done=%b round=%0d expected 1 0 0", ready4, done4, round4);
    end
    n_tests++; if ({nb4, sb4} !== 256'h0) begin
      n_fail++; $display("FAIL rst_mid_data: got nb=%h sboxw=%h expected 0", nb4, sb4);
    end
    start_op(0, 2'b01, PT, CT192, 13, 1'b1);
    wait_done(0, 30, cyc, ct, seen);
    e = sb_q.pop_front();
    n_tests++; if (!seen || ct !== e.ct) begin n_fail++; $display("FAIL rst_rerun_ct: got %h expected %h", ct, e.ct); end
    n_tests++; if (cyc !== e.lat) begin n_fail++; $display("FAIL rst_rerun_latency: got %0d expected %0d", cyc, e.lat); end
    $display("[TB] op after reset ct=%h latency=%0d", ct, cyc);
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    for (int k = 0; k < 4; k++)
      for (int r = 0; r < 16; r++) rk_mem[k][r] = '0;
    expand_key(0);
    expand_key(1);
    expand_key(2);
    cur_kl[0] = 2'b10; cur_kl[1] = 2'b10; cur_kl[2] = 2'b10;

    test_reset();
    test_reserved();
    test_aes256();
    test_widths();
    test_abort();
    test_ignore_next();
    test_back_to_back();
    test_reset_mid();

    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_empty: got %0d entries expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
